mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-cache refills and D-cache line reads/writebacks onto one
// single-port memory, alternating between the two sides when both request.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int MEM_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_wready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int LW  = $clog2(BURST_LEN);
  localparam int OFF = LW + 2;
  localparam int KW  = LW + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF) - 1);
  localparam logic [KW-1:0]     K_LAST    = KW'(BURST_LEN - 1);
  localparam logic [KW-1:0]     K_END     = KW'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_d_q, gnt_d_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       r_q, r_d;
  logic [MEM_LAT-1:0]  pipe_q;
  logic [ADDR_W-1:0]   base_q;
  logic                grant, take_d, issue, ret, rd_state;

  assign rd_state = (state_q == I_RD) || (state_q == D_RD);
  assign issue    = rd_state && (k_q != K_END);
  assign ret      = pipe_q[MEM_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_d_q <= 1'b0;
      k_q     <= '0;
      r_q     <= '0;
      pipe_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      k_q       <= k_d;
      r_q       <= r_d;
      // Issue marker travels MEM_LAT cycles to line up with mem_rdata
      pipe_q[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (grant) base_q <= (take_d ? d_addr : i_addr) & ~LINE_MASK;
  end

  always_comb begin
    state_d = state_q;
    gnt_d_d = gnt_d_q;
    k_d     = k_q;
    r_d     = r_q;
    grant   = 1'b0;
    take_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          // gnt_d_q remembers the last winner; on a tie the other side goes
          take_d  = d_req && (!i_req || !gnt_d_q);
          gnt_d_d = take_d;
          k_d     = '0;
          r_d     = '0;
          state_d = take_d ? (d_we ? D_WR : D_RD) : I_RD;
        end
      end
      I_RD, D_RD: begin
        if (issue) k_d = k_q + 1'b1;
        if (ret) begin
          r_d = r_q + 1'b1;
          if (r_q == K_LAST) state_d = DONE;
        end
      end
      D_WR: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_wready  = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_done    = 1'b0;
    if (issue || state_q == D_WR) begin
      mem_en   = 1'b1;
      mem_addr = base_q | ADDR_W'({k_q[LW-1:0], 2'b00});
    end
    if (state_q == D_WR) begin
      mem_we    = 1'b1;
      d_wready  = 1'b1;
      mem_wdata = d_wdata;
    end
    if (ret) begin
      if (gnt_d_q) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
    end
    if (state_q == DONE) begin
      d_done = gnt_d_q;
      i_done = !gnt_d_q;
    end
  end

endmodule
